// File: rtl/instr_encoder.sv
// Request-to-instruction encoder with a 4-entry output FIFO.
// Illegal opcodes are accepted, dropped, and raise a sticky error flag.
module instr_encoder (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_OP,
  input  logic [1:0]  REQ_RN,
  input  logic [1:0]  REQ_RM,
  input  logic [1:0]  REQ_RX,
  input  logic [1:0]  REQ_MODE,
  input  logic [1:0]  REQ_CIN,
  input  logic [3:0]  REQ_AMT,
  input  logic [3:0]  REQ_AMT2,
  output logic [15:0] INSTR,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [2:0]  COUNT,
  output logic        ERR
);

  typedef enum logic [3:0] {
    OP_ADR = 4'd0,  OP_ADM = 4'd1,  OP_ADI = 4'd2,  OP_SBR = 4'd3,
    OP_SBM = 4'd4,  OP_SBI = 4'd5,  OP_MLR = 4'd6,  OP_MLM = 4'd7,
    OP_XSL = 4'd8,  OP_XSR = 4'd9,  OP_BBO = 4'd10, OP_BFE = 4'd11,
    OP_LDR = 4'd12, OP_STI = 4'd13
  } op_e;

  typedef enum logic [4:0] {
    C_ADR = 5'b00001, C_ADM = 5'b00010, C_ADI = 5'b00011,
    C_SBR = 5'b00100, C_SBM = 5'b00101, C_SBI = 5'b00110,
    C_MLR = 5'b00111, C_MLM = 5'b01000, C_XSL = 5'b01001,
    C_XSR = 5'b01010, C_BBO = 5'b01011, C_LDR = 5'b11000,
    C_STI = 5'b11001
  } code_e;

  op_e         op;
  logic [15:0] enc_word;
  logic        op_legal;
  logic [10:0] reg_fields;
  logic [10:0] imm_fields;
  logic [10:0] shf_fields;
  logic [10:0] bbo_fields;
  logic [10:0] mem_fields;

  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        err;
  logic        accept;
  logic        push;
  logic        pop;

  assign op = op_e'(REQ_OP);

  // Low 11-bit payloads shared by each instruction class.
  assign reg_fields = {1'b0, REQ_CIN, REQ_MODE, REQ_RX, REQ_RN, REQ_RM};
  assign imm_fields = {REQ_RN, 9'b0};
  assign shf_fields = {1'b0, REQ_CIN, REQ_AMT, 2'b00, REQ_RM};
  assign bbo_fields = {7'b0, REQ_RN, REQ_RM};
  assign mem_fields = {2'b00, REQ_MODE[0], REQ_RN, REQ_RM, REQ_AMT};

  always_comb begin
    enc_word = '0;
    op_legal = 1'b1;
    case (op)
      OP_ADR:  enc_word = {C_ADR, reg_fields};
      OP_SBR:  enc_word = {C_SBR, reg_fields};
      OP_MLR:  enc_word = {C_MLR, reg_fields};
      OP_ADM:  enc_word = {C_ADM, 11'b0};
      OP_SBM:  enc_word = {C_SBM, 11'b0};
      OP_MLM:  enc_word = {C_MLM, 11'b0};
      OP_ADI:  enc_word = {C_ADI, imm_fields};
      OP_SBI:  enc_word = {C_SBI, imm_fields};
      OP_XSL:  enc_word = {C_XSL, shf_fields};
      OP_XSR:  enc_word = {C_XSR, shf_fields};
      OP_BBO:  enc_word = {C_BBO, bbo_fields};
      OP_BFE:  enc_word = {4'b0110, ~REQ_AMT2, REQ_AMT, 2'b00, REQ_RM};
      OP_LDR:  enc_word = {C_LDR, mem_fields};
      OP_STI:  enc_word = {C_STI, mem_fields};
      default: op_legal = 1'b0;
    endcase
  end

  assign REQ_READY   = (count != 3'd4);
  assign accept      = REQ_VALID && REQ_READY;
  assign push        = accept && op_legal;
  assign pop         = INSTR_READY && (count != 3'd0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (accept && !op_legal) err <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  assign COUNT       = count;
  assign ERR         = err;
  assign INSTR_VALID = (count != 3'd0);
  assign INSTR       = (count != 3'd0) ? mem[rd_ptr] : '0;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port REQ_VALID, input, 1 bit: request present.
REQ-004 SHALL have port REQ_READY, output, 1 bit: request accepted this cycle when high with REQ_VALID.
REQ-005 SHALL have port REQ_OP, input, 4 bits: 0 ADR, 1 ADM, 2 ADI, 3 SBR, 4 SBM, 5 SBI, 6 MLR, 7 MLM, 8 XSL, 9 XSR, 10 BBO, 11 BFE, 12 LDR, 13 STI, 14-15 illegal.
REQ-006 SHALL have ports REQ_RN, REQ_RM, REQ_RX, each input, 2 bits: register indices.
REQ-007 SHALL have port REQ_MODE, input, 2 bits: post-op shift mode (register forms) or scale flag in bit 0 (LDR/STI).
REQ-008 SHALL have port REQ_CIN, input, 2 bits: carry-in / shift-in mode.
REQ-009 SHALL have ports REQ_AMT and REQ_AMT2, each input, 4 bits: shift amount / offset and BFE left amount.
REQ-010 SHALL have port INSTR, output, 16 bits: head instruction word.
REQ-011 SHALL have port INSTR_VALID, output, 1 bit: INSTR holds a valid word.
REQ-012 SHALL have port INSTR_READY, input, 1 bit: consumer takes INSTR when high with INSTR_VALID.
REQ-013 SHALL have port COUNT, output, 3 bits: FIFO occupancy, 0-4.
REQ-014 SHALL have port ERR, output, 1 bit: sticky illegal-op flag.

Function
REQ-015 SHALL encode each accepted request combinationally and write the word into a 4-entry FIFO on the accepting edge.
REQ-016 SHALL encode ADR/SBR/MLR (opcodes 00001/00100/00111) as [15:11]=opcode, [10]=0, [9:8]=CIN, [7:6]=MODE, [5:4]=RX, [3:2]=RN, [1:0]=RM.
REQ-017 SHALL encode ADM/SBM/MLM (00010/00101/01000) as opcode with [10:0]=0.
REQ-018 SHALL encode ADI/SBI (00011/00110) as opcode, [10:9]=RN, [8:0]=0.
REQ-019 SHALL encode XSL/XSR (01001/01010) as opcode, [10]=0, [9:8]=CIN, [7:4]=AMT, [3:2]=0, [1:0]=RM.
REQ-020 SHALL encode BBO (01011) as opcode, [10:4]=0, [3:2]=RN, [1:0]=RM.
REQ-021 SHALL encode BFE as [15:12]=0110, [11:8]=~AMT2, [7:4]=AMT, [3:2]=0, [1:0]=RM.
REQ-022 SHALL encode LDR/STI (11000/11001) as opcode, [10:9]=0, [8]=MODE[0], [7:6]=RN, [5:4]=RM, [3:0]=AMT.
REQ-023 SHALL drive REQ_READY = (COUNT < 4), independent of INSTR_READY; no pass-through when full.
REQ-024 SHALL, on an illegal REQ_OP handshake, accept the request, write nothing, and set ERR on that edge.
REQ-025 SHALL hold ERR high until reset.
REQ-026 SHALL drive INSTR_VALID = (COUNT != 0).
REQ-027 SHALL drive INSTR from the head entry, and 16'h0000 when COUNT = 0.
REQ-028 SHALL give one-cycle latency: a word accepted into an empty FIFO is on INSTR with INSTR_VALID the following cycle.
REQ-029 SHALL, on simultaneous push and pop, keep COUNT unchanged and preserve order.
REQ-030 SHALL make a pop with COUNT = 0 a no-op.
REQ-031 SHALL wrap read and write pointers modulo 4.
REQ-032 SHALL deliver words strictly in acceptance order.

Reset
REQ-033 SHALL, with nRST low, immediately clear COUNT, pointers and ERR, forcing INSTR_VALID=0, INSTR=0 and REQ_READY=1.
REQ-034 SHALL discard FIFO contents on reset mid-operation; no partial pop or push completes on the reset edge.
REQ-035 SHALL resume accepting requests on the first rising CLK edge after nRST deasserts.

Verification
REQ-036 ADR RN=2 RM=1 RX=3 MODE=2 CIN=1, INSTR_READY=1 -> next cycle INSTR=16'h09B9, INSTR_VALID=1.
REQ-037 BFE AMT=3 AMT2=5 RM=2, then LDR MODE=1 RN=1 RM=2 AMT=7 -> INSTR=16'h6A32 then 16'hC167.
REQ-038 Five back-to-back requests, INSTR_READY=0 -> COUNT reaches 4, REQ_READY=0 on the fifth, and only 4 words are stored.
REQ-039 Full FIFO with INSTR_READY=1 and REQ_VALID=1 -> pop this cycle, push the next cycle, COUNT returns to 4, order preserved across pointer wrap.
REQ-040 REQ_OP=14 -> ERR=1, COUNT unchanged, ERR held; nRST low with 3 entries -> COUNT=0, INSTR=0, ERR=0 asynchronously.
